// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter: each granted requester keeps the resource for up
// to its programmed weight in cycles. A weight of 0 disables the requester.
module weighted_rr_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned WEIGHT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          REQ,
    input  logic                  cfg_we,
    input  logic [$clog2(N)-1:0]  cfg_sel,
    input  logic [WEIGHT_W-1:0]   cfg_weight,
    output logic [N-1:0]          GNT,
    output logic [$clog2(N)-1:0]  GNT_ID,
    output logic                  GNT_NEW,
    output logic                  busy
);
    localparam int unsigned IDW = $clog2(N);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t              state_q, state_d;
    logic [IDW-1:0]      ptr_q, ptr_d, owner_d, pick, cand;
    logic [WEIGHT_W-1:0] limit_q, limit_d, cnt_q, cnt_d;
    logic [WEIGHT_W-1:0] weight_q [N];
    logic [N-1:0]        elig, gnt_d;
    logic                found, tenure_end, new_d;
    int unsigned         idx;

    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < N; i++) begin
            elig[i] = REQ[i] && (weight_q[i] != '0);
        end
    end

    // First eligible requester scanning ptr, ptr+1, ... with wrap-around.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            cand = IDW'(idx);
            if (!found && elig[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = GNT_ID;
        limit_d    = limit_q;
        cnt_d      = cnt_q;
        gnt_d      = GNT;
        new_d      = 1'b0;
        tenure_end = (state_q == OWNED) && (!REQ[GNT_ID] || (cnt_q == limit_q));

        if (((state_q == IDLE) || tenure_end) && found) begin
            state_d     = OWNED;
            owner_d     = pick;
            gnt_d       = '0;
            gnt_d[pick] = 1'b1;
            new_d       = 1'b1;
            limit_d     = weight_q[pick];
            cnt_d       = WEIGHT_W'(1);
            ptr_d       = (pick == IDW'(N - 1)) ? '0 : pick + IDW'(1);
        end else if ((state_q == OWNED) && !tenure_end) begin
            cnt_d = cnt_q + WEIGHT_W'(1);
        end else begin
            state_d = IDLE;
            gnt_d   = '0;
            owner_d = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            limit_q <= '0;
            cnt_q   <= '0;
            GNT     <= '0;
            GNT_ID  <= '0;
            GNT_NEW <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            limit_q <= limit_d;
            cnt_q   <= cnt_d;
            GNT     <= gnt_d;
            GNT_ID  <= owner_d;
            GNT_NEW <= new_d;
        end
    end

    // Searches on the write edge still see the old table (non-blocking update).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N; i++) begin
                weight_q[i] <= WEIGHT_W'(1);
            end
        end else if (cfg_we && (32'(cfg_sel) < N)) begin
            weight_q[cfg_sel] <= cfg_weight;
        end
    end

    assign busy = |GNT;

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Scoreboard bench for weighted_rr_arbiter: per-cycle stimulus vectors push the
// expected {GNT, GNT_ID, GNT_NEW, busy}, popped and compared one cycle later.
module tb_weighted_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] REQ;
    logic       cfg_we;
    logic [1:0] cfg_sel;
    logic [3:0] cfg_weight;
    logic [3:0] GNT;
    logic [1:0] GNT_ID;
    logic       GNT_NEW;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sb [$];

    typedef struct packed {
        logic       rst_n;
        logic [3:0] req;
        logic       we;
        logic [1:0] sel;
        logic [3:0] wt;
        logic [3:0] gnt;
        logic       nw;
    } vec_t;

    weighted_rr_arbiter #(.N(4), .WEIGHT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .REQ(REQ), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_weight(cfg_weight), .GNT(GNT), .GNT_ID(GNT_ID), .GNT_NEW(GNT_NEW), .busy(busy)
    );

    always #5 clk = ~clk;

    wire [7:0] obs = {GNT, GNT_ID, GNT_NEW, busy};

    function automatic logic [7:0] exp_of(input logic [3:0] g, input logic nw);
        logic [1:0] id;
        id = 2'd0;
        for (int i = 0; i < 4; i++) if (g[i]) id = 2'(i);
        return {g, id, nw, |g};
    endfunction

    function automatic vec_t v(input logic r, input logic [3:0] req, input logic we,
                               input logic [1:0] sel, input logic [3:0] wt,
                               input logic [3:0] gnt, input logic nw);
        return '{rst_n: r, req: req, we: we, sel: sel, wt: wt, gnt: gnt, nw: nw};
    endfunction

    task automatic drive_step(input vec_t t);
        rst_n      = t.rst_n;
        REQ        = t.req;
        cfg_we     = t.we;
        cfg_sel    = t.sel;
        cfg_weight = t.wt;
        sb.push_back(exp_of(t.gnt, t.nw));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vec_t tv [$];
        logic [7:0] e;
        tv.push_back(v(0, 4'hF, 0, 0, 0, 4'b0000, 0));
        tv.push_back(v(0, 4'hF, 0, 0, 0, 4'b0000, 0));
        foreach (tv[i]) begin
            drive_step(tv[i]);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset[%0d]: got gnt/id/new/busy=%b required %b", i, obs, e);
            end
        end
    endtask

    task automatic test_round_robin();
        vec_t tv [$];
        logic [7:0] e;
        logic [3:0] seq [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 8; i++) tv.push_back(v(1, 4'hF, 0, 0, 0, seq[i % 4], 1));
        foreach (tv[i]) begin
            drive_step(tv[i]);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL round_robin[%0d]: got gnt/id/new/busy=%b required %b", i, obs, e);
            end
        end
    endtask

    task automatic test_weights();
        vec_t tv [$];
        logic [7:0] e;
        logic [3:0] g  [6] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b1000};
        logic       nw [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 12; i++)
            tv.push_back(v(1, 4'hF, (i == 0), 2'd1, 4'd3, g[i % 6], nw[i % 6]));
        foreach (tv[i]) begin
            drive_step(tv[i]);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL weights[%0d]: got gnt/id/new/busy=%b required %b", i, obs, e);
            end
        end
    endtask

    task automatic test_early_release();
        vec_t tv [$];
        logic [7:0] e;
        tv.push_back(v(1, 4'b0000, 1, 2'd2, 4'd4, 4'b0000, 0));
        tv.push_back(v(1, 4'b0100, 0, 0, 0, 4'b0100, 1));
        tv.push_back(v(1, 4'b0100, 0, 0, 0, 4'b0100, 0));
        tv.push_back(v(1, 4'b0000, 0, 0, 0, 4'b0000, 0));
        tv.push_back(v(1, 4'b0000, 0, 0, 0, 4'b0000, 0));
        foreach (tv[i]) begin
            drive_step(tv[i]);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL early_release[%0d]: got gnt/id/new/busy=%b required %b", i, obs, e);
            end
        end
    endtask

    task automatic test_disabled();
        vec_t tv [$];
        logic [7:0] e;
        tv.push_back(v(1, 4'b0000, 1, 2'd0, 4'd0, 4'b0000, 0));
        for (int i = 0; i < 3; i++) tv.push_back(v(1, 4'b0001, 0, 0, 0, 4'b0000, 0));
        tv.push_back(v(1, 4'b0011, 0, 0, 0, 4'b0010, 1));
        tv.push_back(v(1, 4'b0011, 0, 0, 0, 4'b0010, 0));
        tv.push_back(v(1, 4'b0011, 0, 0, 0, 4'b0010, 0));
        tv.push_back(v(1, 4'b0011, 0, 0, 0, 4'b0010, 1));
        tv.push_back(v(1, 4'b0011, 1, 2'd0, 4'd1, 4'b0010, 0));
        tv.push_back(v(1, 4'b0011, 0, 0, 0, 4'b0010, 0));
        tv.push_back(v(1, 4'b0011, 0, 0, 0, 4'b0001, 1));
        tv.push_back(v(1, 4'b0011, 0, 0, 0, 4'b0010, 1));
        foreach (tv[i]) begin
            drive_step(tv[i]);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL disabled[%0d]: got gnt/id/new/busy=%b required %b", i, obs, e);
            end
        end
    endtask

    task automatic test_sole_regrant();
        vec_t tv [$];
        logic [7:0] e;
        tv.push_back(v(1, 4'b0000, 1, 2'd3, 4'd2, 4'b0000, 0));
        for (int i = 0; i < 6; i++) tv.push_back(v(1, 4'b1000, 0, 0, 0, 4'b1000, (i % 2 == 0)));
        foreach (tv[i]) begin
            drive_step(tv[i]);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL sole_regrant[%0d]: got gnt/id/new/busy=%b required %b", i, obs, e);
            end
        end
    endtask

    task automatic test_mid_tenure_write();
        vec_t tv [$];
        logic [7:0] e;
        tv.push_back(v(1, 4'b0010, 0, 0, 0, 4'b0010, 1));
        tv.push_back(v(1, 4'b0010, 1, 2'd1, 4'd1, 4'b0010, 0));
        tv.push_back(v(1, 4'b0010, 0, 0, 0, 4'b0010, 0));
        tv.push_back(v(1, 4'b0010, 0, 0, 0, 4'b0010, 1));
        tv.push_back(v(1, 4'b0010, 0, 0, 0, 4'b0010, 1));
        foreach (tv[i]) begin
            drive_step(tv[i]);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL mid_tenure_write[%0d]: got gnt/id/new/busy=%b required %b", i, obs, e);
            end
        end
    endtask

    task automatic test_reset_mid_tenure();
        vec_t tv [$];
        logic [7:0] e;
        tv.push_back(v(1, 4'b0110, 0, 0, 0, 4'b0100, 1));
        tv.push_back(v(1, 4'b0110, 0, 0, 0, 4'b0100, 0));
        tv.push_back(v(0, 4'b0110, 1, 2'd2, 4'd7, 4'b0000, 0));
        tv.push_back(v(0, 4'b0110, 0, 0, 0, 4'b0000, 0));
        tv.push_back(v(1, 4'b0100, 0, 0, 0, 4'b0100, 1));
        tv.push_back(v(1, 4'b0100, 0, 0, 0, 4'b0100, 1));
        foreach (tv[i]) begin
            drive_step(tv[i]);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset_mid_tenure[%0d]: got gnt/id/new/busy=%b required %b", i, obs, e);
            end
        end
    endtask

    task automatic test_max_weight();
        vec_t tv [$];
        logic [7:0] e;
        tv.push_back(v(1, 4'b0000, 1, 2'd0, 4'd15, 4'b0000, 0));
        for (int i = 0; i < 16; i++)
            tv.push_back(v(1, 4'b0001, 0, 0, 0, 4'b0001, (i == 0 || i == 15)));
        foreach (tv[i]) begin
            drive_step(tv[i]);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL max_weight[%0d]: got gnt/id/new/busy=%b required %b", i, obs, e);
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        REQ        = 4'hF;
        cfg_we     = 1'b0;
        cfg_sel    = 2'd0;
        cfg_weight = 4'd0;
        test_reset();
        test_round_robin();
        test_weights();
        test_early_release();
        test_disabled();
        test_sole_regrant();
        test_mid_tenure_write();
        test_reset_mid_tenure();
        test_max_weight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
